// File: rtl/digest_check_pkg.sv
// digest_check_pkg: shared types and default sizing for the digest checker.
//   state_e          - comparison FSM states (idle, running, verdict cycle)
//   DIGEST_WORD_W    - default word width (32)
//   DIGEST_NUM_WORDS - default words per digest (8)
//   DIGEST_IDX_W     - width of a word index for the default digest size
package digest_check_pkg;

    localparam int unsigned DIGEST_WORD_W    = 32;
    localparam int unsigned DIGEST_NUM_WORDS = 8;
    localparam int unsigned DIGEST_IDX_W     = $clog2(DIGEST_NUM_WORDS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/digest_check_word_diff.sv
// word_diff: combinational "words differ" detector.
//   hash_i - computed digest word
//   exp_i  - expected digest word
//   diff_o - 1 when any bit of the two words differs
module word_diff #(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] hash_i,
    input  logic [WORD_W-1:0] exp_i,
    output logic              diff_o
);

    assign diff_o = |(hash_i ^ exp_i);

endmodule

// File: rtl/digest_check.sv
// digest_check: sequential multi-word digest comparator.
// A start pulse in idle opens a run; NUM_WORDS word pairs are then accepted on
// in_valid && in_ready and their per-word inequality is OR-folded. After the last
// word a one-cycle done pulse is issued and match holds the verdict until the
// next accepted start.
// Ports:
//   clock, reset     - rising-edge clock, asynchronous active-high reset
//   start            - begin a comparison (honoured in idle only)
//   in_valid/ready   - word-pair handshake; in_ready is high while running
//   hash_word        - computed digest word
//   exp_word         - expected digest word
//   busy             - comparison in progress
//   done             - one-cycle verdict pulse
//   match            - 1 when every word pair was equal
//   mismatch_idx     - index of first differing word (DIGEST_CHECK_IDX_EN only)
// Optional feature: define DIGEST_CHECK_IDX_EN to add mismatch_idx.
module digest_check
    import digest_check_pkg::*;
#(
    parameter int unsigned WORD_W    = DIGEST_WORD_W,
    parameter int unsigned NUM_WORDS = DIGEST_NUM_WORDS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            hash_word,
    input  logic [WORD_W-1:0]            exp_word,
    output logic                         busy,
    output logic                         done,
`ifdef DIGEST_CHECK_IDX_EN
    output logic [$clog2(NUM_WORDS)-1:0] mismatch_idx,
`endif
    output logic                         match
);

    localparam int unsigned IdxW = $clog2(NUM_WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

    state_e          state_q;
    logic [IdxW-1:0] cnt_q;
    logic            diff_q;
    logic            diff_d;
    logic            busy_q;
    logic            done_q;
    logic            match_q;
    logic            word_diff_w;
    logic            accept;
    logic            last_word;

    word_diff #(
        .WORD_W (WORD_W)
    ) u_word_diff (
        .hash_i (hash_word),
        .exp_i  (exp_word),
        .diff_o (word_diff_w)
    );

    assign in_ready  = (state_q == StRun);
    assign accept    = in_ready && in_valid;
    assign last_word = (cnt_q == LastIdx);
    // Folded diff including the word on the bus, so the final word is in the verdict.
    assign diff_d    = diff_q | word_diff_w;

`ifdef DIGEST_CHECK_IDX_EN
    logic [IdxW-1:0] first_idx_q;
    logic [IdxW-1:0] first_idx_d;
    logic [IdxW-1:0] idx_q;

    // Latch the counter only on the first differing word of the run.
    always_comb begin
        first_idx_d = first_idx_q;
        if (!diff_q && word_diff_w) begin
            first_idx_d = cnt_q;
        end
    end

    assign mismatch_idx = idx_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            diff_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
`ifdef DIGEST_CHECK_IDX_EN
            first_idx_q <= '0;
            idx_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRun;
                        cnt_q       <= '0;
                        diff_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        match_q     <= 1'b0;
`ifdef DIGEST_CHECK_IDX_EN
                        first_idx_q <= '0;
                        idx_q       <= '0;
`endif
                    end
                end
                StRun: begin
                    if (accept) begin
                        diff_q      <= diff_d;
`ifdef DIGEST_CHECK_IDX_EN
                        first_idx_q <= first_idx_d;
`endif
                        if (last_word) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            match_q <= ~diff_d;
`ifdef DIGEST_CHECK_IDX_EN
                            idx_q   <= diff_d ? first_idx_d : '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + IdxW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign match = match_q;

endmodule
